// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite loader: FSM states, sprite
// geometry and the 2-bit palette code meanings.
package sprite_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int SPR_H_SIZE   = 16;
  localparam int SPR_V_SIZE   = 16;
  localparam int PIX_PER_WORD = 16;

  localparam logic [1:0] PAL_TRANSPARENT = 2'b00;
  localparam logic [1:0] PAL_WHITE       = 2'b01;
  localparam logic [1:0] PAL_OUTLINE     = 2'b10;
  localparam logic [1:0] PAL_ACCENT      = 2'b11;

endpackage

// File: rtl/sprite_loader.sv
// Serializes packed processor words into one palette code per cycle for the
// sprite RAM, walking the write address row-major across the 16x16 sprite.
//
// state | meaning
// IDLE  | waiting for a word; wr_ready high unless start is asserted
// SHIFT | writing one pixel per cycle from the captured word
module sprite_loader
  import sprite_pkg::*;
#(
  parameter int ADDR   = 8,
  parameter int PIX_W  = 2,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr_valid,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              we,
  output logic [ADDR-1:0]   addr_w,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              busy,
  output logic              done
);

  localparam int         PPW      = WORD_W / PIX_W;
  localparam logic [3:0] LAST_IDX = 4'(PPW - 1);

  state_e            state_q, state_d;
  logic [ADDR-1:0]   addr_q, addr_d;
  logic [3:0]        idx_q, idx_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    done_d  = 1'b0;
    if (start) begin
      state_d = IDLE;
      addr_d  = '0;
      idx_d   = '0;
      sr_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_valid) begin
            sr_d    = wr_data;
            idx_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          sr_d   = sr_q >> PIX_W;
          addr_d = addr_q + 1'b1;
          idx_d  = idx_q + 4'd1;
          done_d = (addr_q == {ADDR{1'b1}});
          if (idx_q == LAST_IDX) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      done_q  <= done_d;
    end
  end

  // start squashes the write of the cycle it arrives in, so an aborted word
  // leaves nothing past the last pixel written before the abort.
  assign we        = (state_q == SHIFT) && !start;
  assign busy      = (state_q == SHIFT);
  assign wr_ready  = (state_q == IDLE) && !start;
  assign addr_w    = addr_q;
  assign pixel_out = sr_q[PIX_W-1:0];
  assign done      = done_q;

endmodule

// File: doc/sprite_loader.md
SPRITE_LOADER -- requirements
Module: sprite_loader

Interface
REQ-001 Parameter ADDR, default 8, sets the sprite RAM write address width (256 entries for a 16x16 sprite).
REQ-002 Parameter PIX_W, default 2, sets the palette code width per pixel.
REQ-003 Parameter WORD_W, default 32, sets the processor data word width; PIX_PER_WORD = WORD_W/PIX_W = 16.
REQ-004 Port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port start, input, 1, one-cycle pulse that rewinds the loader to address 0 and aborts any word in progress.
REQ-007 Port wr_valid, input, 1, processor presents a packed pixel word.
REQ-008 Port wr_data, input, WORD_W, 16 packed codes; pixel k is in bits [2k+1:2k], with pixel 0 in the LSBs.
REQ-009 Port wr_ready, output, 1, loader can accept a word this cycle.
REQ-010 Port we, output, 1, sprite RAM write enable.
REQ-011 Port addr_w, output, ADDR, sprite RAM write address, ordered {row[3:0], col[3:0]}.
REQ-012 Port pixel_out, output, PIX_W, palette code written to RAM.
REQ-013 Port busy, output, 1, high while serializing a word.
REQ-014 Port done, output, 1, one-cycle pulse when the last RAM entry (address 255) has been written.

Function
REQ-015 The loader SHALL use two states: IDLE and SHIFT.
REQ-016 In IDLE, wr_ready SHALL be 1, except in a cycle where start=1, when it SHALL be 0.
REQ-017 In IDLE, a transfer (wr_valid & wr_ready) SHALL latch wr_data into a shift register, clear the pixel index, and enter SHIFT.
REQ-018 In SHIFT, wr_ready SHALL be 0 and busy SHALL be 1.
REQ-019 In each SHIFT cycle, the loader SHALL drive we=1, addr_w = the address counter, and pixel_out = shift register [1:0].
REQ-020 In the same cycle, the shift register SHALL shift right by PIX_W, and both the address counter and the pixel index SHALL increment.
REQ-021 After exactly 16 SHIFT cycles (pixel index 15), the loader SHALL return to IDLE.
REQ-022 Latency: for a word accepted at the posedge ending cycle N, writes SHALL occur in cycles N+1..N+16, and wr_ready SHALL be 1 again in cycle N+17.
REQ-023 Throughput SHALL be one word per 17 cycles; 16 words fill the sprite.
REQ-024 Outside SHIFT, we SHALL be 0.
REQ-025 The address counter SHALL be ADDR bits wide and wrap from 255 to 0 without stalling.
REQ-026 done SHALL pulse high for exactly the one cycle following the write at address 255.
REQ-027 start SHALL force the state to IDLE, clear the address counter, the pixel index and the shift register, and suppress done, taking effect on the next cycle.
REQ-028 start has priority over every other event; a word in flight when start arrives is discarded with no further writes.
REQ-029 If start and wr_valid occur in the same IDLE cycle, the word SHALL NOT be accepted (wr_ready=0 that cycle).
REQ-030 wr_data SHALL be sampled only on the transfer cycle; later changes to wr_data SHALL have no effect.

Reset
REQ-031 On reset=1 at a posedge, the loader SHALL be in IDLE with the address counter, pixel index and shift register all 0.
REQ-032 Reset SHALL drive we=0, addr_w=0, pixel_out=0, busy=0, done=0, and wr_ready=1 in the first cycle after reset deasserts.
REQ-033 Reset mid-SHIFT SHALL abort the word with no further writes; reset has priority over start.

Structure
REQ-034 Package sprite_pkg SHALL hold the state enum {IDLE, SHIFT}, SPR_H_SIZE=16, SPR_V_SIZE=16, PIX_PER_WORD=16 and the palette code constants (00 transparent, 01 white, 10 outline, 11 accent).
REQ-035 The design SHALL be a single module with no sub-module; the FSM, the 4-bit pixel index, the ADDR-bit address counter and the WORD_W shift register all live in it.
REQ-036 All outputs SHALL be driven directly from registers or state decode, with no combinational path from wr_data to any output.

Verification
REQ-037 Reset, then one word 32'hE4E4_E4E4 -> we high for 16 cycles; addr_w 0..15; pixel_out sequence 0,1,2,3 repeated; wr_ready low for those 16 cycles, high in the 17th.
REQ-038 Sixteen back-to-back words with wr_valid held high -> 256 writes at addr_w 0..255; done pulses once, the cycle after addr 255; next write goes to addr 0.
REQ-039 start asserted on the 5th SHIFT cycle -> writes stop after addr 3; next accepted word writes from addr 0; done not asserted.
REQ-040 start and wr_valid both high in IDLE -> no transfer, we stays 0, addr counter 0; wr_valid held for one more cycle -> accepted.
REQ-041 reset asserted mid-word at addr 9 -> the following cycle shows we=0, busy=0, wr_ready=1; the next word writes from addr 0.
REQ-042 wr_data changed every cycle during SHIFT -> pixel_out reflects only the word captured at the transfer cycle.
